// File: rtl/bnn_xnor_kernel_if.sv
// Operand and partial-sum bus for one BNN XNOR kernel PE.
// The master drives the window and psum_in; the slave returns psum_out.
interface bnn_xnor_kernel_if #(
    parameter int N_TAPS = 9,
    parameter int PSUM_W = 7
);
    logic [N_TAPS-1:0] activation_in;
    logic [N_TAPS-1:0] weight_in;
    logic [PSUM_W-1:0] psum_in;
    logic [PSUM_W-1:0] psum_out;

    modport master (
        output activation_in,
        output weight_in,
        output psum_in,
        input  psum_out
    );

    modport slave (
        input  activation_in,
        input  weight_in,
        input  psum_in,
        output psum_out
    );
endinterface

// File: rtl/bnn_xnor_kernel.sv
// 3x3 binary convolution PE: XNOR-popcount of a window plus an
// incoming partial sum, registered once, wrapping modulo 2^PSUM_W.
module bnn_xnor_kernel #(
    parameter int N_TAPS = 9,
    parameter int PSUM_W = 7
) (
    input  logic                clk_in,
    input  logic                rst_in,
    bnn_xnor_kernel_if.slave    bus
);

    logic [N_TAPS-1:0] match;
    logic [PSUM_W-1:0] pop;
    logic [PSUM_W-1:0] sum_next;
    logic [PSUM_W-1:0] psum_q;

    // Tap k of the activation pairs only with tap k of the weight.
    assign match = ~(bus.activation_in ^ bus.weight_in);

    // Count matching taps; PSUM_W is wide enough to hold N_TAPS.
    always_comb begin
        pop = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            pop = pop + PSUM_W'(match[k]);
        end
    end

    // Unsigned add, overflow intentionally wraps (no saturation).
    assign sum_next = bus.psum_in + pop;

    // Output register; reset clears it without waiting for a clock.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            psum_q <= '0;
        end else begin
            psum_q <= sum_next;
        end
    end

    assign bus.psum_out = psum_q;

endmodule

// File: tb/tb_bnn_xnor_kernel.sv
// Directed-table and random-stream bench for bnn_xnor_kernel.
// Expected sums are hand-computed or derived from a popcount model.
module tb_bnn_xnor_kernel;

    localparam int N_TAPS = 9;
    localparam int PSUM_W = 7;

    logic clk_in;
    logic rst_in;

    bnn_xnor_kernel_if #(.N_TAPS(N_TAPS), .PSUM_W(PSUM_W)) bus ();

    bnn_xnor_kernel #(.N_TAPS(N_TAPS), .PSUM_W(PSUM_W)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus.slave)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        string       name;
        logic [8:0]  act;
        logic [8:0]  wgt;
        logic [6:0]  psum;
        logic [6:0]  exp;
    } vec_t;

    vec_t vecs[10];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [6:0] got,
                         input logic [6:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (%b) expected %0d",
                     name, got, got, exp);
        end
    endtask

    task automatic drive(input logic [8:0] a, input logic [8:0] w,
                         input logic [6:0] p);
        bus.activation_in = a;
        bus.weight_in     = w;
        bus.psum_in       = p;
    endtask

    function automatic logic [6:0] model(input logic [8:0] a,
                                         input logic [8:0] w,
                                         input logic [6:0] p);
        logic [8:0] m;
        logic [6:0] c;
        m = ~(a ^ w);
        c = 7'd0;
        for (int k = 0; k < 9; k++) c = c + {6'd0, m[k]};
        return p + c;
    endfunction

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] a;
        logic [8:0] w;
        logic [6:0] exp;

        vecs[0] = '{"all_match_alt", 9'b101010101, 9'b101010101, 7'd0,   7'd9};
        vecs[1] = '{"all_match_ones", 9'h1FF, 9'h1FF, 7'd0,   7'd9};
        vecs[2] = '{"all_match_zero", 9'h000, 9'h000, 7'd0,   7'd9};
        vecs[3] = '{"no_match",       9'h1FF, 9'h000, 7'd0,   7'd0};
        vecs[4] = '{"seven_match", 9'b110000000, 9'b010000001, 7'd0, 7'd7};
        vecs[5] = '{"chain_40",    9'b000011111, 9'b000000111, 7'd40, 7'd47};
        vecs[6] = '{"wrap_120",       9'h155, 9'h155, 7'd120, 7'd1};
        vecs[7] = '{"wrap_127_one",   9'h1FF, 9'h001, 7'd127, 7'd0};
        vecs[8] = '{"hold_127",       9'h1FF, 9'h000, 7'd127, 7'd127};
        vecs[9] = '{"chain_100",      9'h0F0, 9'h0FF, 7'd100, 7'd105};

        // Load a nonzero value, then reset asynchronously between edges.
        rst_in = 1'b1;
        drive(9'h1FF, 9'h1FF, 7'd20);
        @(posedge clk_in);
        #2;
        check("preload", bus.psum_out, 7'd29);
        drive(9'($urandom), 9'($urandom), 7'($urandom));
        rst_in = 1'b0;
        #1;
        check("async_reset", bus.psum_out, 7'd0);
        @(posedge clk_in);
        #2;
        check("reset_hold", bus.psum_out, 7'd0);

        // Release at a falling edge; the next edge gives a real sum.
        @(negedge clk_in);
        rst_in = 1'b1;
        drive(9'b000011111, 9'b000000111, 7'd3);
        @(posedge clk_in);
        #2;
        check("post_reset", bus.psum_out, 7'd10);

        // Directed table, one vector per cycle.
        foreach (vecs[i]) begin
            @(negedge clk_in);
            drive(vecs[i].act, vecs[i].wgt, vecs[i].psum);
            @(posedge clk_in);
            #2;
            check(vecs[i].name, bus.psum_out, vecs[i].exp);
        end

        // Back-to-back random stream with a mid-stream reset.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            rst_in = 1'b1;
            a = 9'($urandom);
            w = 9'($urandom);
            drive(a, w, 7'd0);
            exp = model(a, w, 7'd0);
            @(posedge clk_in);
            #2;
            check("stream", bus.psum_out, exp);
            if (i == 50) begin
                #1;
                rst_in = 1'b0;
                #1;
                check("midstream_reset", bus.psum_out, 7'd0);
            end
        end

        // Random stream with nonzero incoming partial sums.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            a = 9'($urandom);
            w = 9'($urandom);
            exp = 7'($urandom);
            drive(a, w, exp);
            exp = model(a, w, exp);
            @(posedge clk_in);
            #2;
            check("stream_psum", bus.psum_out, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
